ysyx_23060208_pcgen: RTL and testbench

YSYX_23060208_PCGEN -- requirements
Module: ysyx_23060208_pcgen

---
 rtl/ysyx_23060208_pcgen.sv | 127 ++++++++++++
 tb/tb_ysyx_23060208_pcgen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_pcgen.sv
// ysyx_23060208_pcgen -- fetch PC generator.
//
// Issues sequential fetch addresses to the fetch stage with a valid/ready
// handshake, applies branch and trap redirects (trap wins), aligns
// redirect targets down to instruction boundaries, and supports a
// halt/resume mode. Every output is taken straight from a register.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pc_ready           fetch accepts pc this cycle
//   br_valid/target    branch redirect request and target
//   trap_valid/target  trap/mret redirect request and target
//   halt_req           level request to stop issuing PCs
//   resume             pulse to leave HALT
//   pc, pc_valid       offered fetch address and its valid
//   flush              one-cycle pulse after a redirect
//   misalign           one-cycle pulse when a redirect target was misaligned
//   halted             FSM is in HALT
//   issue_cnt          count of completed pc handshakes
//
// state | meaning
// BOOT  | single cycle after reset, nothing offered
// RUN   | pc offered to fetch, advances on handshake
// HALT  | issuing stopped, redirects still land in pc
module ysyx_23060208_pcgen #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned              INST_BYTES   = 4,
  parameter int unsigned              CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_ready,
  input  logic                  br_valid,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  flush,
  output logic                  misalign,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  issue_cnt
);

  localparam int unsigned ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
    {{(DATA_WIDTH-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INST_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  valid_w;
  logic                  handshake;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redir_tgt;

  assign valid_w   = (state_q == RUN);
  assign handshake = valid_w & pc_ready;
  assign redirect  = trap_valid | br_valid;
  assign redir_tgt = trap_valid ? trap_target : br_target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      BOOT:    state_d = RUN;
      // pc_valid is always 1 in RUN, so halting waits for the handshake
      // that retires the pc currently on offer.
      RUN:     if (halt_req && handshake) state_d = HALT;
      HALT:    if (resume && !halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (handshake) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      pc_d  = pc_q + PC_STEP;
    end

    // A redirect beats the sequential step but the handshake still counts.
    if (redirect) begin
      pc_d       = redir_tgt & ALIGN_MASK;
      flush_d    = 1'b1;
      misalign_d = |redir_tgt[ALIGN_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_w;
  assign flush     = flush_q;
  assign misalign  = misalign_q;
  assign halted    = (state_q == HALT);
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060208_pcgen.sv
module tb_ysyx_23060208_pcgen;

  logic        clk;
  logic        rst;
  logic        pc_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        misalign;
  logic        halted;
  logic [31:0] issue_cnt;

  ysyx_23060208_pcgen dut (
    .clk        (clk),
    .rst        (rst),
    .pc_ready   (pc_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .trap_valid (trap_valid),
    .trap_target(trap_target),
    .halt_req   (halt_req),
    .resume     (resume),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .misalign   (misalign),
    .halted     (halted),
    .issue_cnt  (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        v;
    logic        f;
    logic        m;
    logic        h;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;

  // Monitor: the expectation queued with a vector describes the outputs
  // after the clock edge that consumes that vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (pc !== e.pc || pc_valid !== e.v || flush !== e.f ||
          misalign !== e.m || halted !== e.h || issue_cnt !== e.cnt) begin
        bad++;
        $display("FAIL vec%0d: got pc=%h v=%b f=%b m=%b h=%b cnt=%0d, want pc=%h v=%b f=%b m=%b h=%b cnt=%0d",
                 e.id, pc, pc_valid, flush, misalign, halted, issue_cnt,
                 e.pc, e.v, e.f, e.m, e.h, e.cnt);
      end
    end
  end

  task automatic step(input logic r, input logic rdy,
                      input logic tv, input logic [31:0] tt,
                      input logic bv, input logic [31:0] bt,
                      input logic hq, input logic rs,
                      input logic [31:0] e_pc, input logic e_v, input logic e_f,
                      input logic e_m, input logic e_h, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst         = r;
    pc_ready    = rdy;
    trap_valid  = tv;
    trap_target = tt;
    br_valid    = bv;
    br_target   = bt;
    halt_req    = hq;
    resume      = rs;
    e.id  = vec_id;
    e.pc  = e_pc;
    e.v   = e_v;
    e.f   = e_f;
    e.m   = e_m;
    e.h   = e_h;
    e.cnt = e_cnt;
    exp_q.push_back(e);
    vec_id++;
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    rst = 1'b1; pc_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_target = '0; halt_req = 1'b0; resume = 1'b0;

    //   rst rdy tv tt            bv bt            hq rs   pc            v  f  m  h  cnt
    // reset, then boot and stream
    step(1, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 0, 0, 0, 0, 0);
    step(1, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 0, 0, 0, 0, 0);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 1, 0, 0, 0, 0);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0004, 1, 0, 0, 0, 1);
    // backpressure at 0x80000004
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0004, 1, 0, 0, 0, 1);
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0004, 1, 0, 0, 0, 1);
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0004, 1, 0, 0, 0, 1);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0008, 1, 0, 0, 0, 2);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_000C, 1, 0, 0, 0, 3);
    // trap + branch + handshake together: trap wins, count still advances
    step(0, 1, 1, 32'h8000_1000, 1, 32'h8000_2000, 0, 0, 32'h8000_1000, 1, 1, 0, 0, 4);
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_1000, 1, 0, 0, 0, 4);
    // misaligned branch
    step(0, 0, 0, Z,            1, 32'h8000_0106, 0, 0, 32'h8000_0104, 1, 1, 1, 0, 4);
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0104, 1, 0, 0, 0, 4);
    // misaligned trap beats aligned branch
    step(0, 1, 1, 32'h8000_0302, 1, 32'h8000_0500, 0, 0, 32'h8000_0300, 1, 1, 1, 0, 5);
    // move to 0x80000010 for the halt sequence
    step(0, 0, 0, Z,            1, 32'h8000_0010, 0, 0, 32'h8000_0010, 1, 1, 0, 0, 5);
    // halt waits for the handshake
    step(0, 0, 0, Z,            0, Z,            1, 0,  32'h8000_0010, 1, 0, 0, 0, 5);
    step(0, 0, 0, Z,            0, Z,            1, 0,  32'h8000_0010, 1, 0, 0, 0, 5);
    step(0, 1, 0, Z,            0, Z,            1, 0,  32'h8000_0014, 0, 0, 0, 1, 6);
    step(0, 1, 0, Z,            0, Z,            1, 0,  32'h8000_0014, 0, 0, 0, 1, 6);
    // resume with halt_req still high keeps HALT
    step(0, 1, 0, Z,            0, Z,            1, 1,  32'h8000_0014, 0, 0, 0, 1, 6);
    // branch while halted
    step(0, 1, 0, Z,            1, 32'h8000_0200, 0, 0, 32'h8000_0200, 0, 1, 0, 1, 6);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0200, 0, 0, 0, 1, 6);
    // resume
    step(0, 1, 0, Z,            0, Z,            0, 1,  32'h8000_0200, 1, 0, 0, 0, 6);
    // resume in RUN is ignored
    step(0, 0, 0, Z,            0, Z,            0, 1,  32'h8000_0200, 1, 0, 0, 0, 6);
    // wrap
    step(0, 0, 0, Z,            1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 1, 0, 0, 6);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h0000_0000, 1, 0, 0, 0, 7);
    // reset in RUN beats a simultaneous redirect
    step(1, 1, 1, 32'h8000_1000, 1, 32'h8000_2000, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 1, 0, 0, 0, 0);
    // redirect during BOOT still enters RUN on schedule
    step(1, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 0, 0, 0, 0, 0);
    step(0, 1, 0, Z,            1, 32'h8000_0040, 0, 0, 32'h8000_0040, 1, 1, 0, 0, 0);
    step(0, 1, 0, Z,            0, Z,            0, 0,  32'h8000_0044, 1, 0, 0, 0, 1);
    // reset from HALT
    step(0, 1, 0, Z,            0, Z,            1, 0,  32'h8000_0048, 0, 0, 0, 1, 2);
    step(1, 1, 0, Z,            0, Z,            1, 0,  32'h8000_0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, Z,            0, Z,            0, 0,  32'h8000_0000, 1, 0, 0, 0, 0);

    @(negedge clk);
    pc_ready = 1'b0; br_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
